mem_stage_lsu: RTL and testbench

- Load/store unit of the MEM pipeline stage. Sits between the EX/MEM pipeline register and the word-addressed data RAM.
- Converts byte addresses into word indices and performs sub-word loads with sign/zero extension.
- Performs sub-word stores as a two-cycle read-modify-write, stalling the pipeline for one cycle.
- Flags misaligned, out-of-range and illegal accesses instead of touching memory.

---
 rtl/mem_stage_lsu_if.sv | 42 ++++
 rtl/mem_stage_lsu.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Request/response and RAM-side signals of the MEM-stage load/store unit.
//   master : pipeline/environment side (drives requests and RAM read data)
//   slave  : the LSU itself (drives stall, load result, fault and RAM controls)
// Signals:
//   req_valid/req_load/req_store/req_size/req_unsigned/req_addr/req_wdata : access request
//   stall, load_data, load_valid, fault                                   : pipeline response
//   mem_read_en, mem_write_en, mem_address, mem_in                         : to word RAM
//   mem_out                                                                : RAM read data
interface mem_stage_lsu_if #(
   parameter int unsigned LEN_WORD = 32
);
   logic                req_valid;
   logic                req_load;
   logic                req_store;
   logic [1:0]          req_size;
   logic                req_unsigned;
   logic [LEN_WORD-1:0] req_addr;
   logic [LEN_WORD-1:0] req_wdata;
   logic                stall;
   logic [LEN_WORD-1:0] load_data;
   logic                load_valid;
   logic                fault;
   logic                mem_read_en;
   logic                mem_write_en;
   logic [LEN_WORD-1:0] mem_address;
   logic [LEN_WORD-1:0] mem_in;
   logic [LEN_WORD-1:0] mem_out;

   modport master (
      output req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
      output mem_out,
      input  stall, load_data, load_valid, fault,
      input  mem_read_en, mem_write_en, mem_address, mem_in
   );

   modport slave (
      input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_out,
      output stall, load_data, load_valid, fault,
      output mem_read_en, mem_write_en, mem_address, mem_in
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit between the EX/MEM register and a word-addressed RAM.
// Converts byte addresses to word indices, extends sub-word loads, and performs sub-word
// stores as a two-cycle read-modify-write (one stall cycle). Illegal, misaligned and
// out-of-range requests raise a one-cycle fault pulse and never touch memory.
// Build option: define LSU_SUBWORD_EN to enable byte/halfword accesses and the RMW FSM;
// without it only word accesses are legal and stall is tied low.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous reset, active low
//   bus     : mem_stage_lsu_if.slave (request, response and RAM signals)
// Lane logic assumes 4-byte words (LEN_WORD = 32).
module mem_stage_lsu #(
   parameter int unsigned LEN_WORD = 32,
   parameter int unsigned SIZE_MEM = 1024
) (
   input logic            i_clk,
   input logic            i_reset,
   mem_stage_lsu_if.slave bus
);
   localparam logic [1:0] SzByte = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;
   localparam logic [1:0] SzWord = 2'b10;

   logic [LEN_WORD-1:0] w_idx;
   logic                w_dir_ok;
   logic                w_align_ok;
   logic                w_range_ok;
   logic                w_legal;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [LEN_WORD-1:0] w_ext;
   logic                w_load_valid_d;
   logic                w_fault_d;
   logic [LEN_WORD-1:0] r_load_data;
   logic                r_load_valid;
   logic                r_fault;

`ifdef LSU_SUBWORD_EN
   typedef enum logic [0:0] {StIdle, StRmwWrite} state_e;
   state_e              r_state;
   state_e              w_state_next;
   logic [LEN_WORD-1:0] w_merge;
   logic [LEN_WORD-1:0] r_merge;
   logic [LEN_WORD-1:0] r_idx;
`endif

   assign w_idx      = {2'b00, bus.req_addr[LEN_WORD-1:2]};
   assign w_dir_ok   = bus.req_load ^ bus.req_store;
   assign w_range_ok = w_idx < LEN_WORD'(SIZE_MEM);
   assign w_legal    = w_dir_ok & w_align_ok & w_range_ok;

   // Size legality doubles as the alignment check; size 11 always falls to default.
   always_comb begin
      w_align_ok = 1'b0;
      case (bus.req_size)
`ifdef LSU_SUBWORD_EN
         SzByte:  w_align_ok = 1'b1;
         SzHalf:  w_align_ok = ~bus.req_addr[0];
`endif
         SzWord:  w_align_ok = (bus.req_addr[1:0] == 2'b00);
         default: w_align_ok = 1'b0;
      endcase
   end

   // Little-endian lane pick from the RAM word.
   assign w_byte = bus.mem_out[{bus.req_addr[1:0], 3'b000} +: 8];
   assign w_half = bus.mem_out[{bus.req_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_ext = bus.mem_out;
      if (bus.req_size == SzByte) begin
         w_ext = {{(LEN_WORD-8){w_byte[7] & ~bus.req_unsigned}}, w_byte};
      end else if (bus.req_size == SzHalf) begin
         w_ext = {{(LEN_WORD-16){w_half[15] & ~bus.req_unsigned}}, w_half};
      end
   end

`ifdef LSU_SUBWORD_EN
   // Old word with the target lane overwritten by the low store data.
   always_comb begin
      w_merge = bus.mem_out;
      if (bus.req_size == SzByte) begin
         w_merge[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
      end else begin
         w_merge[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
      end
   end
`endif

   // Next state and RAM/stall outputs; everything is forced low while reset is held.
   always_comb begin
`ifdef LSU_SUBWORD_EN
      w_state_next     = r_state;
`endif
      w_load_valid_d   = 1'b0;
      w_fault_d        = 1'b0;
      bus.stall        = 1'b0;
      bus.mem_read_en  = 1'b0;
      bus.mem_write_en = 1'b0;
      bus.mem_address  = '0;
      bus.mem_in       = '0;
      if (i_reset) begin
`ifdef LSU_SUBWORD_EN
         if (r_state == StRmwWrite) begin
            // Held request is ignored; write back the merged word.
            bus.mem_write_en = 1'b1;
            bus.mem_in       = r_merge;
            bus.mem_address  = r_idx;
            w_state_next     = StIdle;
         end else
`endif
         if (bus.req_valid) begin
            if (!w_legal) begin
               w_fault_d = 1'b1;
            end else if (bus.req_load) begin
               bus.mem_read_en = 1'b1;
               bus.mem_address = w_idx;
               w_load_valid_d  = 1'b1;
            end else if (bus.req_size == SzWord) begin
               bus.mem_write_en = 1'b1;
               bus.mem_address  = w_idx;
               bus.mem_in       = bus.req_wdata;
            end
`ifdef LSU_SUBWORD_EN
            else begin
               bus.mem_read_en = 1'b1;
               bus.mem_address = w_idx;
               bus.stall       = 1'b1;
               w_state_next    = StRmwWrite;
            end
`endif
         end
      end
   end

`ifdef LSU_SUBWORD_EN
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_merge <= '0;
         r_idx   <= '0;
      end else if (r_state == StIdle && w_state_next == StRmwWrite) begin
         r_merge <= w_merge;
         r_idx   <= w_idx;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_load_valid <= w_load_valid_d;
         r_fault      <= w_fault_d;
         if (w_load_valid_d) begin
            r_load_data <= w_ext;
         end
      end
   end

   assign bus.load_data  = r_load_data;
   assign bus.load_valid = r_load_valid;
   assign bus.fault      = r_fault;
endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
   localparam int unsigned LW = 32;
   localparam int unsigned SM = 1024;
   localparam int unsigned AW = $clog2(SM);
`ifdef LSU_SUBWORD_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [LW-1:0] ram  [SM];
   logic [LW-1:0] gold [SM];

   // Observations captured by run_access.
   logic          oa_stall, oa_rd, oa_wr, o_lv, o_flt, ob_stall, ob_rd, ob_wr, o_lv2, o_flt2;
   logic [LW-1:0] oa_addr, oa_in, o_data, ob_addr, ob_in;

   mem_stage_lsu_if #(.LEN_WORD(LW)) lsu_bus ();

   mem_stage_lsu #(.LEN_WORD(LW), .SIZE_MEM(SM)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (lsu_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word RAM with combinational read.
   assign lsu_bus.mem_out = (lsu_bus.mem_address < SM) ? ram[lsu_bus.mem_address[AW-1:0]] : '0;
   always @(posedge clk) begin
      if (lsu_bus.mem_write_en && lsu_bus.mem_address < SM) begin
         ram[lsu_bus.mem_address[AW-1:0]] <= lsu_bus.mem_in;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit m_legal(input logic ld, input logic st, input logic [1:0] sz,
                                  input logic [31:0] addr);
      int unsigned nb;
      if (ld == st) return 1'b0;
      if (sz == 2'b11) return 1'b0;
      if (!SUBWORD && sz != 2'b10) return 1'b0;
      nb = 1 << sz;
      if (addr % nb != 0) return 1'b0;
      if (addr / 4 >= SM) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] addr);
      longint unsigned mask, v;
      int unsigned     nb;
      nb   = 1 << sz;
      mask = (64'd1 << (8 * nb)) - 1;
      v    = (64'(gold[addr / 4]) >> (8 * (addr % 4))) & mask;
      if (!uns && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic [31:0] m_store(input logic [1:0] sz, input logic [31:0] addr,
                                           input logic [31:0] wd);
      longint unsigned mask, res;
      int unsigned     nb, sh;
      nb   = 1 << sz;
      sh   = 8 * (addr % 4);
      mask = ((64'd1 << (8 * nb)) - 1) << sh;
      res  = (64'(gold[addr / 4]) & ~mask) | ((64'(wd) << sh) & mask);
      return res[31:0];
   endfunction

   task automatic model_commit(input logic ld, input logic st, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] wd);
      if (m_legal(ld, st, sz, addr) && st) gold[addr / 4] = m_store(sz, addr, wd);
   endtask

   // Issues one request (held one extra cycle if the DUT stalls) and records outputs.
   // Entered and left at posedge+1.
   task automatic run_access(input logic ld, input logic st, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd);
      lsu_bus.req_valid    = 1'b1;
      lsu_bus.req_load     = ld;
      lsu_bus.req_store    = st;
      lsu_bus.req_size     = sz;
      lsu_bus.req_unsigned = uns;
      lsu_bus.req_addr     = addr;
      lsu_bus.req_wdata    = wd;
      @(negedge clk);
      oa_stall = lsu_bus.stall;
      oa_rd    = lsu_bus.mem_read_en;
      oa_wr    = lsu_bus.mem_write_en;
      oa_addr  = lsu_bus.mem_address;
      oa_in    = lsu_bus.mem_in;
      @(posedge clk);
      #1;
      o_lv   = lsu_bus.load_valid;
      o_flt  = lsu_bus.fault;
      o_data = lsu_bus.load_data;
      if (!oa_stall) lsu_bus.req_valid = 1'b0;
      @(negedge clk);
      ob_stall = lsu_bus.stall;
      ob_rd    = lsu_bus.mem_read_en;
      ob_wr    = lsu_bus.mem_write_en;
      ob_addr  = lsu_bus.mem_address;
      ob_in    = lsu_bus.mem_in;
      @(posedge clk);
      #1;
      lsu_bus.req_valid = 1'b0;
      o_lv2  = lsu_bus.load_valid;
      o_flt2 = lsu_bus.fault;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [4:0]    ctl;
      logic [LW-1:0] data;
      rst_n = 1'b0;
      // A request held during reset must not leak to any output.
      lsu_bus.req_valid = 1'b1; lsu_bus.req_load = 1'b0; lsu_bus.req_store = 1'b1;
      lsu_bus.req_size = 2'b00; lsu_bus.req_addr = 32'h15; lsu_bus.req_wdata = 32'hAB;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ctl = {lsu_bus.stall, lsu_bus.mem_read_en, lsu_bus.mem_write_en,
             lsu_bus.load_valid, lsu_bus.fault};
      n_checks++;
      if (ctl !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b, expected %b", ctl, 5'b0);
      end
      data = lsu_bus.mem_address | lsu_bus.mem_in | lsu_bus.load_data;
      n_checks++;
      if (data !== '0) begin
         n_errors++;
         $display("FAIL reset_data: got %h, expected %h", data, 32'h0);
      end
      lsu_bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_word_load();
      run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      n_checks++;
      if (oa_addr !== 32'd5) begin
         n_errors++; $display("FAIL lw_addr: got %h, expected %h", oa_addr, 32'd5);
      end
      n_checks++;
      if ({oa_stall, ob_stall, oa_rd, o_lv, o_lv2} !== 5'b00110) begin
         n_errors++;
         $display("FAIL lw_ctrl: got %b, expected %b", {oa_stall, ob_stall, oa_rd, o_lv, o_lv2},
                  5'b00110);
      end
      n_checks++;
      if (o_data !== 32'h5) begin
         n_errors++; $display("FAIL lw_data: got %h, expected %h", o_data, 32'h5);
      end
   endtask

   task automatic test_subword_store();
      bit            e_rmw;
      logic [LW-1:0] e_merge;
      e_rmw   = m_legal(1'b0, 1'b1, 2'b00, 32'h15);
      e_merge = m_store(2'b00, 32'h15, 32'hAB);
      run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h15, 32'hAB);
      model_commit(1'b0, 1'b1, 2'b00, 32'h15, 32'hAB);
      n_checks++;
      if ({oa_stall, ob_stall, ob_wr, o_flt} !== {e_rmw, 1'b0, e_rmw, !e_rmw}) begin
         n_errors++;
         $display("FAIL sb_ctrl: got %b, expected %b", {oa_stall, ob_stall, ob_wr, o_flt},
                  {e_rmw, 1'b0, e_rmw, !e_rmw});
      end
      if (e_rmw) begin
         n_checks++;
         if (ob_in !== e_merge || ob_addr !== 32'd5) begin
            n_errors++;
            $display("FAIL sb_write: got in=%h addr=%h, expected in=%h addr=%h", ob_in, ob_addr,
                     e_merge, 32'd5);
         end
      end
      run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      n_checks++;
      if (o_data !== gold[5] || ram[5] !== gold[5]) begin
         n_errors++;
         $display("FAIL sb_readback: got load=%h ram=%h, expected %h", o_data, ram[5], gold[5]);
      end
   endtask

   task automatic test_subword_loads();
      logic [1:0]  sz   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] addr [4] = '{32'h15, 32'h15, 32'h14, 32'h14};
      for (int i = 0; i < 4; i++) begin
         bit            e_ok;
         logic [LW-1:0] e_data;
         e_ok   = m_legal(1'b1, 1'b0, sz[i], addr[i]);
         e_data = m_load(sz[i], uns[i], addr[i]);
         run_access(1'b1, 1'b0, sz[i], uns[i], addr[i], 32'h0);
         n_checks++;
         if ({o_lv, o_flt} !== {e_ok, !e_ok}) begin
            n_errors++;
            $display("FAIL subload_ctrl[%0d]: got %b, expected %b", i, {o_lv, o_flt},
                     {e_ok, !e_ok});
         end
         if (e_ok) begin
            n_checks++;
            if (o_data !== e_data) begin
               n_errors++;
               $display("FAIL subload_data[%0d]: got %h, expected %h", i, o_data, e_data);
            end
         end
      end
   endtask

   task automatic test_rejects();
      logic        ld   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic        st   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  sz   [5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
      logic [31:0] addr [5] = '{32'h13, 32'h16, SM * 4, 32'h0, 32'h4};
      for (int i = 0; i < 5; i++) begin
         logic [6:0] got;
         run_access(ld[i], st[i], sz[i], 1'b0, addr[i], 32'hDEADBEEF);
         got = {oa_stall, oa_rd, oa_wr, o_lv, o_flt, ob_wr, o_flt2};
         n_checks++;
         if (got !== 7'b0000100) begin
            n_errors++;
            $display("FAIL reject[%0d]: got %b, expected %b", i, got, 7'b0000100);
         end
      end
   endtask

   task automatic test_reset_in_rmw();
      logic [5:0] ctl;
      lsu_bus.req_valid = 1'b1; lsu_bus.req_load = 1'b0; lsu_bus.req_store = 1'b1;
      lsu_bus.req_size = 2'b01; lsu_bus.req_unsigned = 1'b0;
      lsu_bus.req_addr = 32'h20; lsu_bus.req_wdata = 32'h1234;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      ctl = {lsu_bus.stall, lsu_bus.mem_read_en, lsu_bus.mem_write_en,
             lsu_bus.load_valid, lsu_bus.fault, |lsu_bus.mem_address};
      n_checks++;
      if (ctl !== 6'b0) begin
         n_errors++; $display("FAIL rmw_reset_outputs: got %b, expected %b", ctl, 6'b0);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ram[8] !== 32'h8) begin
         n_errors++; $display("FAIL rmw_reset_ram: got %h, expected %h", ram[8], 32'h8);
      end
      lsu_bus.req_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      n_checks++;
      if (o_data !== 32'h8 || o_lv !== 1'b1) begin
         n_errors++;
         $display("FAIL rmw_reset_readback: got lv=%b data=%h, expected lv=1 data=%h", o_lv,
                  o_data, 32'h8);
      end
   endtask

   task automatic test_word_store();
      run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
      model_commit(1'b0, 1'b1, 2'b10, 32'h14, 32'hDEADBEEF);
      n_checks++;
      if ({oa_stall, oa_wr, oa_rd, ob_wr, o_flt} !== 5'b01000 || oa_in !== 32'hDEADBEEF ||
          oa_addr !== 32'd5) begin
         n_errors++;
         $display("FAIL sw_cycle: got ctrl=%b in=%h addr=%h, expected ctrl=01000 in=%h addr=%h",
                  {oa_stall, oa_wr, oa_rd, ob_wr, o_flt}, oa_in, oa_addr, 32'hDEADBEEF, 32'd5);
      end
      n_checks++;
      if (ram[5] !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL sw_ram: got %h, expected %h", ram[5], 32'hDEADBEEF);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 400; it++) begin
         logic          ld, st, uns;
         logic [1:0]    sz;
         logic [31:0]   addr, wd, idx;
         bit            e_ok, e_ld, e_rmw, e_wst;
         logic [LW-1:0] e_data, e_merge;
         int unsigned   r;
         if ($urandom_range(0, 7) == 0) begin
            // Idle cycle with garbage request fields.
            lsu_bus.req_valid = 1'b0;
            lsu_bus.req_load  = 1'($urandom);
            lsu_bus.req_store = 1'($urandom);
            lsu_bus.req_addr  = $urandom;
            @(negedge clk);
            n_checks++;
            if ({lsu_bus.stall, lsu_bus.mem_read_en, lsu_bus.mem_write_en} !== 3'b0) begin
               n_errors++;
               $display("FAIL idle_enables[%0d]: got %b, expected 000", it,
                        {lsu_bus.stall, lsu_bus.mem_read_en, lsu_bus.mem_write_en});
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({lsu_bus.load_valid, lsu_bus.fault} !== 2'b0) begin
               n_errors++;
               $display("FAIL idle_pulses[%0d]: got %b, expected 00", it,
                        {lsu_bus.load_valid, lsu_bus.fault});
            end
            continue;
         end
         r = $urandom_range(0, 9);
         if (r == 0) begin ld = 1'b1; st = 1'b1; end
         else if (r == 1) begin ld = 1'b0; st = 1'b0; end
         else begin ld = 1'($urandom); st = !ld; end
         r = $urandom_range(0, 7);
         sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
         r = $urandom_range(0, 9);
         idx = (r == 0) ? SM + $urandom_range(0, 15) :
               (r < 3) ? $urandom_range(0, SM - 1) : $urandom_range(0, 15);
         addr = idx * 4 + ((sz == 2'b10 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 3));
         uns  = 1'($urandom);
         wd   = $urandom;
         e_ok    = m_legal(ld, st, sz, addr);
         e_ld    = e_ok && ld;
         e_rmw   = e_ok && st && sz != 2'b10;
         e_wst   = e_ok && st && sz == 2'b10;
         e_data  = e_ld ? m_load(sz, uns, addr) : '0;
         e_merge = (e_ok && st) ? m_store(sz, addr, wd) : '0;
         run_access(ld, st, sz, uns, addr, wd);
         model_commit(ld, st, sz, addr, wd);
         n_checks++;
         if ({oa_stall, oa_rd, oa_wr, o_lv, o_flt} !==
             {e_rmw, e_ld || e_rmw, e_wst, e_ld, !e_ok}) begin
            n_errors++;
            $display("FAIL rand_ctrl_a[%0d]: got %b, expected %b (ld=%b st=%b sz=%b addr=%h)", it,
                     {oa_stall, oa_rd, oa_wr, o_lv, o_flt},
                     {e_rmw, e_ld || e_rmw, e_wst, e_ld, !e_ok}, ld, st, sz, addr);
         end
         n_checks++;
         if (oa_addr !== (e_ok ? addr >> 2 : 32'h0)) begin
            n_errors++;
            $display("FAIL rand_addr[%0d]: got %h, expected %h", it, oa_addr,
                     e_ok ? addr >> 2 : 32'h0);
         end
         n_checks++;
         if ({ob_stall, ob_rd, ob_wr, o_lv2, o_flt2} !== {3'b000, 2'b00} + {2'b00, e_rmw, 2'b00})
         begin
            n_errors++;
            $display("FAIL rand_ctrl_b[%0d]: got %b, expected %b", it,
                     {ob_stall, ob_rd, ob_wr, o_lv2, o_flt2}, {2'b00, e_rmw, 2'b00});
         end
         if (e_ld) begin
            n_checks++;
            if (o_data !== e_data) begin
               n_errors++;
               $display("FAIL rand_load[%0d]: got %h, expected %h (sz=%b uns=%b addr=%h)", it,
                        o_data, e_data, sz, uns, addr);
            end
         end
         if (e_wst) begin
            n_checks++;
            if (oa_in !== wd) begin
               n_errors++; $display("FAIL rand_sw_in[%0d]: got %h, expected %h", it, oa_in, wd);
            end
         end
         if (e_rmw) begin
            n_checks++;
            if (ob_in !== e_merge || ob_addr !== addr >> 2) begin
               n_errors++;
               $display("FAIL rand_rmw[%0d]: got in=%h addr=%h, expected in=%h addr=%h", it,
                        ob_in, ob_addr, e_merge, addr >> 2);
            end
         end
         if (idx < SM) begin
            n_checks++;
            if (ram[idx] !== gold[idx]) begin
               n_errors++;
               $display("FAIL rand_ram[%0d]: word %0d got %h, expected %h", it, idx, ram[idx],
                        gold[idx]);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < SM; i++) begin
         ram[i]  = LW'(i);
         gold[i] = LW'(i);
      end
      lsu_bus.req_valid    = 1'b0;
      lsu_bus.req_load     = 1'b0;
      lsu_bus.req_store    = 1'b0;
      lsu_bus.req_size     = 2'b00;
      lsu_bus.req_unsigned = 1'b0;
      lsu_bus.req_addr     = '0;
      lsu_bus.req_wdata    = '0;
      test_reset();
      test_word_load();
      test_subword_store();
      test_subword_loads();
      test_rejects();
      test_reset_in_rmw();
      test_word_store();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
